// File: rtl/bus_pkg.sv
// Shared types and constants for the bus generator / round-robin arbiter.
package bus_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
  localparam int MAX_PKT_W = 1024;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    PUSH
  } state_t;

  // The destination ID occupies the top ID_W bits of a packet of width pktW.
  function automatic logic [ID_W-1:0] pktDestId(input logic [MAX_PKT_W-1:0] pkt,
                                                input int pktW);
    return pkt[pktW-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Single-bus FSM: round-robin grant, pop the winner's FIFO, then push the
// captured packet to its destination (or every other agent on broadcast).
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int DRVRS = 4,
  parameter int PKT_W = 16,
  parameter logic [ID_W-1:0] BCAST = BROADCAST_ID
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DRVRS-1:0]            i_pndng,
  input  logic [DRVRS-1:0][PKT_W-1:0] i_dPop,
  output logic [DRVRS-1:0]            o_pop,
  output logic [DRVRS-1:0]            o_push,
  output logic [PKT_W-1:0]            o_dPush
);

  localparam int RR_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  state_t           r_state, w_nextState;
  logic [RR_W-1:0]  r_rr, w_nextRr;
  logic [RR_W-1:0]  r_grant, w_nextGrant;
  logic [RR_W-1:0]  w_idx, w_winner;
  logic             w_found;
  logic [PKT_W-1:0] r_pkt, w_nextPkt;
  logic [PKT_W-1:0] r_dPush, w_nextDPush;
  logic [DRVRS-1:0] r_pop, w_nextPop;
  logic [DRVRS-1:0] r_push, w_nextPush;
  logic [ID_W-1:0]  w_destId;

  assign w_destId = pktDestId(MAX_PKT_W'(r_pkt), PKT_W);

  // Scan from the round-robin pointer and take the first pending agent.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < DRVRS; k++) begin
      w_idx = RR_W'((int'(r_rr) + k) % DRVRS);
      if (!w_found && i_pndng[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextRr    = r_rr;
    w_nextGrant = r_grant;
    w_nextPkt   = r_pkt;
    w_nextDPush = r_dPush;
    w_nextPop   = '0;
    w_nextPush  = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nextPop[w_winner] = 1'b1;
          w_nextPkt           = i_dPop[w_winner];
          w_nextGrant         = w_winner;
          w_nextRr            = (int'(w_winner) == DRVRS - 1) ? '0 : w_winner + RR_W'(1);
          w_nextState         = POP;
        end
      end
      POP: begin
        w_nextDPush = r_pkt;
        // Invalid IDs fall through with no push: the packet is dropped.
        if (w_destId == BCAST) begin
          w_nextPush          = '1;
          w_nextPush[r_grant] = 1'b0;
        end else if (int'(w_destId) < DRVRS) begin
          w_nextPush[w_destId[RR_W-1:0]] = 1'b1;
        end
        w_nextState = PUSH;
      end
      PUSH:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rr    <= '0;
      r_grant <= '0;
      r_pkt   <= '0;
      r_dPush <= '0;
      r_pop   <= '0;
      r_push  <= '0;
    end else begin
      r_state <= w_nextState;
      r_rr    <= w_nextRr;
      r_grant <= w_nextGrant;
      r_pkt   <= w_nextPkt;
      r_dPush <= w_nextDPush;
      r_pop   <= w_nextPop;
      r_push  <= w_nextPush;
    end
  end

  assign o_pop   = r_pop;
  assign o_push  = r_push;
  assign o_dPush = r_dPush;

endmodule

// File: rtl/bus_gnrtr_n_arbiter.sv
// Bus generator: one independent round-robin arbiter per bus, sharing a
// reset that asserts asynchronously and releases in step with clk.
module bus_gnrtr_n_arbiter
  import bus_pkg::*;
#(
  parameter int bits = 1,
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]              pop,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][pckg_sz-1:0]            D_push
);

  logic [1:0] r_rstSync;
  logic       w_rstN;

  // Two-flop synchroniser: clears immediately, releases two edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN = r_rstSync[1];

  for (genvar b = 0; b < bits; b++) begin : g_bus
    bus_rr_arbiter #(
      .DRVRS(drvrs),
      .PKT_W(pckg_sz),
      .BCAST(broadcast)
    ) u_arb (
      .clk    (clk),
      .rst_n  (w_rstN),
      .i_pndng(pndng[b]),
      .i_dPop (D_pop[b]),
      .o_pop  (pop[b]),
      .o_push (push[b]),
      .o_dPush(D_push[b])
    );
  end

endmodule

// File: tb/tb_bus_gnrtr_n_arbiter.sv
// Randomised bench: per-agent source queues feed the DUT; a transaction-level
// round-robin model predicts every pop, push mask and bus word.
module tb_bus_gnrtr_n_arbiter;

  localparam int BITS = 1;
  localparam int DRVRS = 8;
  localparam int PKT_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [BITS-1:0][DRVRS-1:0]            pndng;
  logic [BITS-1:0][DRVRS-1:0][PKT_W-1:0] D_pop;
  logic [BITS-1:0][DRVRS-1:0]            pop;
  logic [BITS-1:0][DRVRS-1:0]            push;
  logic [BITS-1:0][PKT_W-1:0]            D_push;

  int compareCount = 0;
  int mismatchCount = 0;

  logic [PKT_W-1:0] srcQ[DRVRS][$];
  int               modelRr = 0;
  int               modelPhase = 0;
  logic [7:0]       expPush = '0;
  logic [PKT_W-1:0] expPkt = '0;

  bus_gnrtr_n_arbiter #(
    .bits(BITS),
    .drvrs(DRVRS),
    .pckg_sz(PKT_W),
    .broadcast(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pndng (pndng),
    .D_pop (D_pop),
    .pop   (pop),
    .push  (push),
    .D_push(D_push)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [PKT_W-1:0] randPkt();
    int r;
    logic [7:0] d;
    r = $urandom_range(9);
    if (r < 6) d = 8'($urandom_range(DRVRS - 1));
    else if (r < 8) d = 8'hFF;
    else d = 8'($urandom_range(254, DRVRS));
    return {d, 8'($urandom)};
  endfunction

  function automatic int rrPick(input logic [7:0] snap, input int from);
    for (int k = 0; k < DRVRS; k++) begin
      if (snap[(from + k) % DRVRS]) return (from + k) % DRVRS;
    end
    return -1;
  endfunction

  function automatic logic [7:0] deliverMask(input logic [PKT_W-1:0] pkt, input int src);
    int dest;
    dest = int'(pkt[PKT_W-1 -: 8]);
    if (dest == 255) return 8'hFF & ~(8'h01 << src);
    if (dest < DRVRS) return 8'h01 << dest;
    return 8'h00;
  endfunction

  function automatic bit allEmpty();
    for (int i = 0; i < DRVRS; i++) begin
      if (srcQ[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic driveInputs();
    for (int i = 0; i < DRVRS; i++) begin
      pndng[0][i] = (srcQ[i].size() != 0);
      D_pop[0][i] = (srcQ[i].size() != 0) ? srcQ[i][0] : '0;
    end
  endtask

  task automatic takeGrant(input int g);
    expPkt     = srcQ[g].pop_front();
    expPush    = deliverMask(expPkt, g);
    modelRr    = (g + 1) % DRVRS;
    modelPhase = 1;
  endtask

  task automatic applyStimulus(input int cycles, input bit inject);
    logic [7:0] snap;
    int g;
    int a;
    repeat (cycles) begin
      @(negedge clk);
      if (inject && $urandom_range(3) == 0) begin
        a = $urandom_range(DRVRS - 1);
        srcQ[a].push_back(randPkt());
      end
      driveInputs();
      snap = pndng[0];
      @(posedge clk);
      #1;
      case (modelPhase)
        0: begin
          g = rrPick(snap, modelRr);
          if (g < 0) begin
            checkOutput("idlePop", 32'(pop[0]), 0);
            checkOutput("idlePush", 32'(push[0]), 0);
          end else begin
            checkOutput("grantPop", 32'(pop[0]), 32'(8'h01 << g));
            checkOutput("grantPush", 32'(push[0]), 0);
            takeGrant(g);
          end
        end
        1: begin
          checkOutput("popCleared", 32'(pop[0]), 0);
          checkOutput("pushMask", 32'(push[0]), 32'(expPush));
          if (expPush != 0) checkOutput("pushData", 32'(D_push[0]), 32'(expPkt));
          modelPhase = 2;
        end
        default: begin
          checkOutput("pushCleared", 32'(push[0]), 0);
          checkOutput("pushIdlePop", 32'(pop[0]), 0);
          modelPhase = 0;
        end
      endcase
    end
  endtask

  task automatic drainAll();
    bit drained;
    drained = 1'b0;
    for (int n = 0; n < 300 && !drained; n++) begin
      applyStimulus(1, 1'b0);
      if (allEmpty() && modelPhase == 0) drained = 1'b1;
    end
    checkOutput("drainDone", 32'(drained), 1);
  endtask

  task automatic releaseAndGrant();
    bit seen;
    int g;
    logic [7:0] snap;
    seen = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    driveInputs();
    snap = pndng[0];
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (pop[0] != 0) seen = 1'b1;
      else checkOutput("syncWaitPush", 32'(push[0]), 0);
    end
    checkOutput("grantSeen", 32'(seen), 1);
    if (seen) begin
      g = rrPick(snap, 0);
      checkOutput("firstGrant", 32'(pop[0]), 32'(8'h01 << g));
      takeGrant(g);
    end
  endtask

  initial begin
    bit reached;
    pndng = '0;
    D_pop = '0;
    reset = 1'b0;

    for (int i = 0; i < DRVRS; i++) begin
      srcQ[i].push_back({8'($urandom_range(DRVRS - 1)), 8'($urandom)});
    end
    driveInputs();
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("rstPop", 32'(pop[0]), 0);
      checkOutput("rstPush", 32'(push[0]), 0);
      checkOutput("rstDPush", 32'(D_push[0]), 0);
    end
    modelRr = 0;
    modelPhase = 0;
    releaseAndGrant();
    drainAll();

    srcQ[2].push_back(16'h05AB);
    applyStimulus(4, 1'b0);
    srcQ[3].push_back(16'hFF12);
    applyStimulus(4, 1'b0);
    srcQ[1].push_back(16'h0011);
    srcQ[1].push_back(16'h0022);
    srcQ[6].push_back(16'h0066);
    srcQ[6].push_back(16'h0077);
    applyStimulus(14, 1'b0);
    srcQ[4].push_back(16'h20CD);
    applyStimulus(4, 1'b0);

    applyStimulus(600, 1'b1);
    drainAll();

    srcQ[2].push_back(16'h05AB);
    reached = 1'b0;
    for (int n = 0; n < 10 && !reached; n++) begin
      applyStimulus(1, 1'b0);
      if (modelPhase == 2) reached = 1'b1;
    end
    checkOutput("reachedPush", 32'(reached), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncPush", 32'(push[0]), 0);
    checkOutput("asyncDPush", 32'(D_push[0]), 0);
    checkOutput("asyncPop", 32'(pop[0]), 0);
    modelPhase = 0;
    modelRr = 0;
    srcQ[5].push_back(16'h0133);
    srcQ[0].push_back(16'h0244);
    srcQ[7].push_back(16'hFF55);
    repeat (2) @(posedge clk);
    releaseAndGrant();
    drainAll();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/bus_gnrtr_n_arbiter.md
Name: bus_gnrtr_n_arbiter

Overview:
- Bus generator plus round-robin arbiter. It connects `drvrs` agent FIFOs over one or more shared buses.
- Each cycle of work: pick one agent with a pending packet, pop it from that agent's output FIFO, and push it into the input FIFO of the destination agent (or of all other agents for a broadcast).
- Sits between the per-agent FIFOs and the rest of the system-level bus environment.

Parameters:
- bits, 1, number of independent buses (each bus has its own arbiter).
- drvrs, 4, number of agents/FIFOs per bus; 1..255.
- pckg_sz, 16, packet width in bits; must be >8.
- broadcast, 8'hFF, destination-ID value meaning "deliver to all except sender".

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  [bits-1:0][drvrs-1:0]  source FIFO of agent i on bus b is non-empty.
- D_pop  in  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  head-of-FIFO data, first-word-fall-through; valid while pndng is high.
- pop  out  [bits-1:0][drvrs-1:0]  one-cycle pop strobe to the source FIFO.
- push  out  [bits-1:0][drvrs-1:0]  one-cycle push strobe to destination FIFO(s).
- D_push  out  [bits-1:0][pckg_sz-1:0]  bus data, shared by all agents on bus b.

Behaviour:
- Packet format: [pckg_sz-1:pckg_sz-8] = destination ID; remaining bits are payload, never interpreted.
- Reset (reset=0, asynchronous):
  - pop=0, push=0, D_push=0.
  - FSM to IDLE.
  - Round-robin pointer rr=0.
  - Deassertion is synchronised to clk.
- Per-bus FSM with states IDLE, POP, PUSH. All outputs are registered.
- IDLE:
  - If no pndng bit is set: stay in IDLE.
  - Else grant g = first i with pndng[i]=1, scanning rr, rr+1, ..., wrapping modulo drvrs.
  - On the next edge: pop[g]=1 for exactly one cycle; capture D_pop[g] into the packet register; rr <= (g+1) mod drvrs; go to POP.
- POP:
  - Drive D_push = captured packet.
  - Destination ID == broadcast: push[i]=1 for all i != g.
  - Destination ID < drvrs: push[ID]=1. A self-addressed packet (ID==g) is delivered to g.
  - Otherwise (invalid ID): all push bits stay 0 and the packet is dropped. It has still been popped.
  - Go to PUSH.
- PUSH: push returns to 0; D_push holds its last value; go to IDLE.
- Timing: pndng sampled high at edge n -> pop at n+1 -> push at n+2 -> next grant possible at n+3 (one packet per 3 cycles per bus).
- pndng changes while in POP/PUSH are ignored until the FSM is back in IDLE.
- Only one pop bit per bus is ever high; pop and push are never high in the same cycle.
- Buses are fully independent; no cross-bus ordering.
- Reset asserted mid-transaction aborts immediately and the packet is lost. The source FIFO was already popped if the pop cycle had passed.
- Unknown (X) on pndng is treated as 0.

Decomposition:
- Package bus_pkg holds:
  - BROADCAST_ID constant (8'hFF);
  - ID_W = 8;
  - state enum {IDLE, POP, PUSH};
  - a function that extracts the ID from a packet.
- One sub-module, bus_rr_arbiter: single-bus FSM plus round-robin grant. The top instantiates `bits` copies through a generate loop.

Test Plan (bits=1, drvrs=8, pckg_sz=16):
1. Hold reset=0 with pndng=8'hFF -> pop=0, push=0, D_push=0 throughout; release reset -> first grant is agent 0.
2. Unicast: pndng[2]=1, D_pop[2]=16'h05AB -> next cycle pop=8'h04; following cycle push=8'h20, D_push=16'h05AB; then push=0.
3. Broadcast: pndng[3]=1, D_pop[3]=16'hFF12 -> pop=8'h08, then push=8'hF7, D_push=16'hFF12.
4. Round robin: pndng[1] and pndng[6] held high, both with destination 0 -> pop sequence 8'h02, 8'h40, 8'h02, 8'h40, spaced 3 cycles apart; push[0] once per grant.
5. Invalid destination: D_pop[4]=16'h20CD with pndng[4]=1 -> pop=8'h10, push stays 8'h00, FSM back in IDLE 2 cycles later.
6. Async reset: assert reset=0 mid-POP while push=8'h20 -> push=0 and D_push=0 immediately without waiting for a clock edge; after release, arbitration restarts from agent 0.
